spi_xfer_scheduler: RTL and testbench
=====================================

# spi_xfer_scheduler

Sequences complete SPI transfers on `spi_controller` on behalf of two hardware requesters and arbitrates between them round-robin. It sits between the requesters and `spi_controller`'s register-write port, in parallel with the AXI register path. For each granted request it issues the control-register write, then the data-register write, tracks the busy bit to completion, and returns the received word or a timeout error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum number of cycles from the data-register write to busy deasserting; counter width is $clog2(TIMEOUT_CYCLES+1).
- `START_WAIT`, default 16: maximum number of cycles after the data write for busy to rise.
- `BUSY_BIT`, default 0: index of the busy flag in `i_status_reg`.

Ports:
- `FCLK_CLK0` in 1: single clock; every register is clocked on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `i_req_valid` in 2: per-requester transfer request; held high until accepted.
- `o_req_ready` in/out: out 2: one-hot grant; a request is accepted in the cycle where valid & ready.
- `i_req0_ctrl`, `i_req1_ctrl` in 32: control word for each requester.
- `i_req0_tx`, `i_req1_tx` in 32: transmit word for each requester.
- `o_rsp_valid` out 2: one-cycle completion pulse to the owning requester; there is no backpressure.
- `o_rsp_data` out 32: received word, valid while `o_rsp_valid` is nonzero.
- `o_rsp_err` out 1: timeout flag, valid while `o_rsp_valid` is nonzero.
- `o_data_to_registers` out 32: write data to `spi_controller`.
- `o_wr_controll_reg` out 1: one-cycle write strobe for the control register.
- `o_wr_data_reg` out 1: one-cycle write strobe for the data register; this strobe starts the transfer.
- `i_status_reg` in 32: status register of `spi_controller`.
- `i_data_reg` in 32: RX data register of `spi_controller`.
- `o_busy` out 1: high in every state except IDLE.
- `o_owner` out 1: index of the current or most recent owner.

## Operation
- States: IDLE → WR_CTRL → WR_DATA → WAIT_START → WAIT_DONE → RESP → IDLE.
- **IDLE:**
  - `o_req_ready` is combinational and goes to the winner among the asserted `i_req_valid` bits.
  - Priority pointer `rr`: requester `rr` wins if valid; otherwise the other requester wins.
  - On handshake: latch ctrl/tx into internal registers, set `o_owner`, go to WR_CTRL.
- **WR_CTRL:** `o_data_to_registers` = latched ctrl, `o_wr_controll_reg` = 1 for exactly one cycle.
- **WR_DATA:** `o_data_to_registers` = latched tx, `o_wr_data_reg` = 1 for exactly one cycle; clear the wait counter.
- **WAIT_START:**
  - Wait for `i_status_reg[BUSY_BIT]` = 1, then go to WAIT_DONE.
  - If busy has not been seen within `START_WAIT` cycles, go to RESP with err = 1.
- **WAIT_DONE:**
  - When busy = 0, capture `i_data_reg` and go to RESP with err = 0.
  - If the counter from WR_DATA reaches `TIMEOUT_CYCLES`, go to RESP with err = 1 and data = 0.
- **RESP:**
  - `o_rsp_valid[owner]` = 1 for one cycle.
  - `rr` ← ~owner, so the other requester gets priority next.
  - Return to IDLE.
- A request that is not granted keeps waiting; it is never dropped.
- At most one transfer is outstanding. `o_req_ready` is 0 outside IDLE.
- Strobes are never asserted simultaneously. `o_data_to_registers` = 0 when no strobe is active.

## Timing
- Reset values:
  - state IDLE; `rr` = 0; `o_owner` = 0.
  - `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_err` = 0.
  - both strobes = 0; `o_data_to_registers` = 0; `o_busy` = 0.
  - internal ctrl/tx registers = 0.
- All outputs are registered except `o_req_ready`, which is a function of IDLE state, `i_req_valid` and `rr`.
- Cycle-level sequence, with the handshake at cycle 0:
  - cycle 1: ctrl strobe.
  - cycle 2: data strobe.
  - cycle 3: earliest cycle busy can be sampled.
  - busy first seen low in WAIT_DONE at cycle N: response pulse at N+1, IDLE at N+2.
  - The next handshake can occur at N+2.
- Timeout: the error response follows `TIMEOUT_CYCLES` cycles after the data strobe; exact count ±0, verified.
- Simultaneous requests in IDLE: `rr` decides the grant. Two back-to-back transfers with both requesters valid alternate 0, 1, 0, ...
- Reset asserted mid-transfer: all state clears immediately (asynchronously), strobes drop, and no response is issued. The requester must re-request.
- Busy glitching to 0 during WAIT_START does not count as completion.

## Test plan
- Reset only, no requests → all outputs 0, `o_busy` = 0, `o_req_ready` = 00.
- Requester 0: ctrl = 0x0000_0105, tx = 0xA5; model busy high for 20 cycles, RX = 0x3C → ctrl strobe at cycle 1, data strobe at cycle 2, then `o_rsp_valid` = 01, data = 0x3C, err = 0.
- Both requesters valid continuously, 4 transfers → grants 0, 1, 0, 1, each owner receives exactly one pulse per transfer, and the strobes never overlap.
- Busy never rises → err pulse `START_WAIT` cycles after the data strobe, data = 0, state returns to IDLE.
- Busy stuck at 1, `TIMEOUT_CYCLES` = 64 → err = 1 exactly 64 cycles after the data strobe, and the next request is serviced normally.
- `RST_N` pulsed low during WAIT_DONE → outputs return to reset values within the same cycle, no `o_rsp_valid` pulse, and a new request after release completes normally.

Source files
------------

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler that runs full SPI transfers on spi_controller.
// Ports: two requesters (valid/ready, ctrl, tx, rsp), reg-write port, status/rx in.
module spi_xfer_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int START_WAIT     = 16,
  parameter int BUSY_BIT       = 0
) (
  input  logic        FCLK_CLK0,
  input  logic        RST_N,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [31:0] i_req0_ctrl,
  input  logic [31:0] i_req1_ctrl,
  input  logic [31:0] i_req0_tx,
  input  logic [31:0] i_req1_tx,
  output logic [1:0]  o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [31:0] o_data_to_registers,
  output logic        o_wr_controll_reg,
  output logic        o_wr_data_reg,
  input  logic [31:0] i_status_reg,
  input  logic [31:0] i_data_reg,
  output logic        o_busy,
  output logic        o_owner
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_CTRL,
    WR_DATA,
    WAIT_START,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rr;
  logic [31:0]   ctrl_q;
  logic [31:0]   tx_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    grant;
  logic          hs;
  logic [31:0]   sel_ctrl;
  logic [31:0]   sel_tx;
  logic          busy_in;
  logic          start_to;
  logic          done_to;
  logic [31:0]   rsp_data_nxt;
  logic          rsp_err_nxt;

  // ctrl_q is a held copy of the accepted control word; nothing reads it.
  logic unused_ok;
  assign unused_ok = ^{i_status_reg, ctrl_q};

  assign busy_in  = i_status_reg[BUSY_BIT];
  assign cnt_inc  = cnt + CW'(1);
  assign start_to = (cnt_inc == CW'(START_WAIT));
  assign done_to  = (cnt_inc == CW'(TIMEOUT_CYCLES));

  // Requester rr has priority; the other one wins only if rr is idle.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (i_req_valid[rr]) begin
        grant[rr] = 1'b1;
      end else if (i_req_valid[~rr]) begin
        grant[~rr] = 1'b1;
      end
    end
  end

  assign o_req_ready = grant;
  assign hs          = |grant;
  assign sel_ctrl    = grant[1] ? i_req1_ctrl : i_req0_ctrl;
  assign sel_tx      = grant[1] ? i_req1_tx   : i_req0_tx;

  always_comb begin
    state_nxt    = state;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) state_nxt = WR_CTRL;
      end
      WR_CTRL: state_nxt = WR_DATA;
      WR_DATA: state_nxt = WAIT_START;
      WAIT_START: begin
        if (busy_in) begin
          state_nxt = WAIT_DONE;
        end else if (start_to) begin
          state_nxt   = RESP;
          rsp_err_nxt = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_in) begin
          state_nxt    = RESP;
          rsp_data_nxt = i_data_reg;
        end else if (done_to) begin
          state_nxt   = RESP;
          rsp_err_nxt = 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up
  // with the cycle its state occupies.
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      state               <= IDLE;
      rr                  <= 1'b0;
      ctrl_q              <= '0;
      tx_q                <= '0;
      cnt                 <= '0;
      o_owner             <= 1'b0;
      o_busy              <= 1'b0;
      o_wr_controll_reg   <= 1'b0;
      o_wr_data_reg       <= 1'b0;
      o_data_to_registers <= '0;
      o_rsp_valid         <= 2'b00;
      o_rsp_data          <= '0;
      o_rsp_err           <= 1'b0;
    end else begin
      state             <= state_nxt;
      o_busy            <= (state_nxt != IDLE);
      o_wr_controll_reg <= (state_nxt == WR_CTRL);
      o_wr_data_reg     <= (state_nxt == WR_DATA);
      if (state_nxt == WR_CTRL) begin
        o_data_to_registers <= sel_ctrl;
      end else if (state_nxt == WR_DATA) begin
        o_data_to_registers <= tx_q;
      end else begin
        o_data_to_registers <= '0;
      end
      if (hs) begin
        ctrl_q  <= sel_ctrl;
        tx_q    <= sel_tx;
        o_owner <= grant[1];
      end
      // cnt equals the number of cycles elapsed since the data strobe.
      if (state == WR_DATA) begin
        cnt <= CW'(1);
      end else if (state == WAIT_START || state == WAIT_DONE) begin
        cnt <= cnt_inc;
      end
      if (state_nxt == RESP) begin
        o_rsp_valid <= {o_owner, ~o_owner};
      end else begin
        o_rsp_valid <= 2'b00;
      end
      o_rsp_data <= rsp_data_nxt;
      o_rsp_err  <= rsp_err_nxt;
      if (state == RESP) rr <= ~o_owner;
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Scoreboard bench for spi_xfer_scheduler with a behavioural SPI busy model.
// Driver pushes expected strobes/responses; a negedge monitor pops and checks.
module tb_spi_xfer_scheduler;

  localparam int TO = 64;
  localparam int SW = 16;
  localparam int BB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [31:0] r0c, r1c, r0t, r1t;
  logic [1:0]  o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic [31:0] o_data_to_registers;
  logic        o_wr_controll_reg;
  logic        o_wr_data_reg;
  logic [31:0] status;
  logic [31:0] rxd;
  logic        o_busy;
  logic        o_owner;

  always #5 clk = ~clk;

  spi_xfer_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .START_WAIT(SW),
    .BUSY_BIT(BB)
  ) dut (
    .FCLK_CLK0(clk),
    .RST_N(rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req0_ctrl(r0c),
    .i_req1_ctrl(r1c),
    .i_req0_tx(r0t),
    .i_req1_tx(r1t),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err),
    .o_data_to_registers(o_data_to_registers),
    .o_wr_controll_reg(o_wr_controll_reg),
    .o_wr_data_reg(o_wr_data_reg),
    .i_status_reg(status),
    .i_data_reg(rxd),
    .o_busy(o_busy),
    .o_owner(o_owner)
  );

  typedef struct {
    int          owner;
    logic [31:0] ctrl;
    logic [31:0] tx;
  } stb_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // SPI controller model: 0 normal, 1 busy never rises, 2 busy stuck high.
  int          mode = 0;
  int          busy_len = 2;
  logic [31:0] rx_mask = '0;

  initial begin
    status = '0;
    rxd    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (o_wr_data_reg) begin
        rxd = o_data_to_registers ^ rx_mask;
        if (mode == 0) begin
          status[BB] = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1;
          status[BB] = 1'b0;
        end else if (mode == 2) begin
          status[BB] = 1'b1;
        end
      end
    end
  end

  // Monitor
  int cyc = 0;
  int hs_cyc = -100;
  int dat_cyc = -100;
  bit idle_chk = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (idle_chk) begin
          idle_chk = 1'b0;
          chk("rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
          chk("idle_after_rsp", 32'(o_busy), 32'd0);
        end
        chk("strobe_overlap",
            32'(o_wr_controll_reg & o_wr_data_reg), 32'd0);
        if (o_wr_controll_reg) begin
          if (stb_q.size() == 0) begin
            fail("ctrl_strobe", "strobe seen, none expected");
          end else begin
            chk("ctrl_data", o_data_to_registers, stb_q[0].ctrl);
            chk("ctrl_owner", 32'(o_owner), 32'(stb_q[0].owner));
            chk("ctrl_cycle", 32'(cyc - hs_cyc), 32'd1);
          end
        end else if (o_wr_data_reg) begin
          if (stb_q.size() == 0) begin
            fail("data_strobe", "strobe seen, none expected");
          end else begin
            stb_t s;
            s = stb_q.pop_front();
            chk("data_word", o_data_to_registers, s.tx);
            chk("data_cycle", 32'(cyc - hs_cyc), 32'd2);
            dat_cyc = cyc;
          end
        end else begin
          chk("bus_quiet", o_data_to_registers, 32'd0);
        end
        if (|o_rsp_valid) begin
          if (rsp_q.size() == 0) begin
            fail("rsp", $sformatf("got rsp_valid=%b, required none",
                                  o_rsp_valid));
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rsp_valid", 32'(o_rsp_valid),
                (r.owner == 1) ? 32'd2 : 32'd1);
            chk("rsp_data", o_rsp_data, r.data);
            chk("rsp_err", 32'(o_rsp_err), 32'(r.err));
            chk("rsp_latency", 32'(cyc - dat_cyc), 32'(r.lat));
            idle_chk = 1'b1;
          end
        end
        if (|(o_req_ready & i_req_valid)) hs_cyc = cyc;
      end
    end
  end

  task automatic wait_grant(input int r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_req_ready[r] && i_req_valid[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("grant_wait", $sformatf("no grant for req %0d", r));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(output int who);
    bit ok;
    ok  = 1'b0;
    who = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (|(o_req_ready & i_req_valid)) begin
        ok  = 1'b1;
        who = o_req_ready[1] ? 1 : 0;
        break;
      end
    end
    if (!ok) fail("grant_wait", "no grant for either requester");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && stb_q.size() == 0 && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("done_wait", "transfer did not complete");
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int r, input logic [31:0] c,
                        input logic [31:0] t, input logic [31:0] msk,
                        input int m, input int len,
                        input logic [31:0] xd, input logic xe,
                        input int lat);
    mode     = m;
    busy_len = len;
    rx_mask  = msk;
    stb_q.push_back('{owner: r, ctrl: c, tx: t});
    rsp_q.push_back('{owner: r, data: xd, err: xe, lat: lat});
    if (r == 0) begin
      r0c = c;
      r0t = t;
    end else begin
      r1c = c;
      r1t = t;
    end
    i_req_valid[r] = 1'b1;
    wait_grant(r);
    i_req_valid[r] = 1'b0;
    wait_done();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_wr_ctrl"}, 32'(o_wr_controll_reg), 32'd0);
    chk({tag, "_wr_data"}, 32'(o_wr_data_reg), 32'd0);
    chk({tag, "_bus"}, o_data_to_registers, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, o_rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
    chk({tag, "_owner"}, 32'(o_owner), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    i_req_valid = 2'b00;
    r0c = '0;
    r1c = '0;
    r0t = '0;
    r1t = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    chk("reset_ready", 32'(o_req_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(o_req_ready), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Both requesters valid: grants must alternate 0,1,0,1.
    mode     = 0;
    busy_len = 5;
    rx_mask  = 32'h0000_00F0;
    stb_q.push_back('{owner: 0, ctrl: 32'h0000_0201, tx: 32'h11});
    stb_q.push_back('{owner: 1, ctrl: 32'h0000_0302, tx: 32'h22});
    stb_q.push_back('{owner: 0, ctrl: 32'h0000_0203, tx: 32'h33});
    stb_q.push_back('{owner: 1, ctrl: 32'h0000_0304, tx: 32'h44});
    rsp_q.push_back('{owner: 0, data: 32'hE1, err: 1'b0, lat: 6});
    rsp_q.push_back('{owner: 1, data: 32'hD2, err: 1'b0, lat: 6});
    rsp_q.push_back('{owner: 0, data: 32'hC3, err: 1'b0, lat: 6});
    rsp_q.push_back('{owner: 1, data: 32'hB4, err: 1'b0, lat: 6});
    r0c = 32'h0000_0201;
    r0t = 32'h11;
    r1c = 32'h0000_0302;
    r1t = 32'h22;
    i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_any(who);
      chk("grant_order", 32'(who), 32'(k % 2));
      if (k == 3) i_req_valid = 2'b00;
      if (who == 0) begin
        r0c = 32'h0000_0203;
        r0t = 32'h33;
      end else begin
        r1c = 32'h0000_0304;
        r1t = 32'h44;
      end
    end
    wait_done();

    // Requester 0, busy high 20 cycles, rx 0x3C.
    single(0, 32'h0000_0105, 32'hA5, 32'h99, 0, 20,
           32'h3C, 1'b0, 21);

    // Busy never rises: start-wait error.
    single(1, 32'h0000_0207, 32'h5A, 32'hFF, 1, 0,
           32'h0, 1'b1, SW);

    // Busy stuck high: completion timeout.
    single(0, 32'h0000_0309, 32'h77, 32'h0F, 2, 0,
           32'h0, 1'b1, TO);
    status[BB] = 1'b0;

    // Normal service after a timeout.
    single(1, 32'h0000_040B, 32'h1234_5678, 32'hFFFF_0000, 0, 3,
           32'hEDCB_5678, 1'b0, 4);

    // Reset pulsed during WAIT_DONE: no response, clean restart.
    mode = 2;
    stb_q.push_back('{owner: 1, ctrl: 32'h0000_050D, tx: 32'h99});
    r1c = 32'h0000_050D;
    r1t = 32'h99;
    i_req_valid[1] = 1'b1;
    wait_grant(1);
    i_req_valid[1] = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    status[BB] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stb_q_after_reset", 32'(stb_q.size()), 32'd0);
    single(0, 32'h0000_060F, 32'hC0DE, 32'h0000_FF00, 0, 4,
           32'h3FDE, 1'b0, 5);

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("stb_q_empty", 32'(stb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
